// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch predictor slice.
package bp_pkg;

  // 2-bit saturating direction counter states
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  // Tag field sized for the smallest legal table (ENTRIES = 4); narrower tags are zero-extended
  localparam int unsigned BP_TAG_MAX_W = 28;

  typedef struct packed {
    logic                    valid;
    logic                    is_jump;
    logic [BP_TAG_MAX_W-1:0] tag;
    logic [31:0]             target;
  } bp_entry_t;

  localparam bp_ctr_t BP_CTR_RESET = WNT;
  localparam bp_ctr_t BP_CTR_ALLOC = WT;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, execute resolution and statistics signals of the branch predictor.
interface branch_predictor_if;
  // fetch side
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_pc_f;
  // execute side
  logic        upd_valid_e;
  logic        upd_is_jump_e;
  logic [31:0] upd_pc_e;
  logic        upd_taken_e;
  logic [31:0] upd_target_e;
  logic        pred_taken_e;
  logic [31:0] pred_pc_e;
  logic        mispredict_e;
  logic [31:0] redirect_pc_e;
  // statistics
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  modport master (
    output pc_f, upd_valid_e, upd_is_jump_e, upd_pc_e, upd_taken_e, upd_target_e,
           pred_taken_e, pred_pc_e,
    input  pred_taken_f, pred_pc_f, mispredict_e, redirect_pc_e, branch_cnt, mispred_cnt
  );

  modport slave (
    input  pc_f, upd_valid_e, upd_is_jump_e, upd_pc_e, upd_taken_e, upd_target_e,
           pred_taken_e, pred_pc_e,
    output pred_taken_f, pred_pc_f, mispredict_e, redirect_pc_e, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predictor_sat_ctr.sv
// 2-bit saturating counter next-state function.
module bp_sat_ctr
  import bp_pkg::*;
(
  input  bp_ctr_t ctr_i,
  input  logic    inc_i,
  output bp_ctr_t ctr_o
);

  // increment toward ST or decrement toward SNT, holding at the rails
  always_comb begin
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != ST) ctr_o = bp_ctr_t'(ctr_i + 2'd1);
    end else begin
      if (ctr_i != SNT) ctr_o = bp_ctr_t'(ctr_i - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit BHT: combinational fetch lookup, execute-side
// mispredict/redirect, one-cycle training update and resolution statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 64
) (
  input  logic               clk,
  input  logic               rst,
  branch_predictor_if.slave  bp
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  function automatic logic [BP_TAG_MAX_W-1:0] tag_of(input logic [31:0] pc);
    logic [TAG_W-1:0] t;
    t = pc[31:IDX_W+2];
    return (BP_TAG_MAX_W)'(t);
  endfunction

  bp_entry_t   entry_q [ENTRIES];
  bp_ctr_t     ctr_q   [ENTRIES];
  logic [31:0] branch_cnt_q, mispred_cnt_q;

  // ---- fetch lookup ----
  logic [IDX_W-1:0] f_idx;
  logic             f_hit;

  // lookup sees only registered state, so a same-cycle update is not visible yet
  always_comb begin
    f_idx           = bp.pc_f[IDX_W+1:2];
    f_hit           = entry_q[f_idx].valid && (entry_q[f_idx].tag == tag_of(bp.pc_f));
    bp.pred_taken_f = f_hit && (entry_q[f_idx].is_jump || ctr_q[f_idx][1]);
    bp.pred_pc_f    = bp.pred_taken_f ? entry_q[f_idx].target : bp.pc_f + 32'd4;
  end

  // ---- resolution ----
  // compare the actual outcome against what fetch predicted; all zero when idle
  always_comb begin
    bp.mispredict_e  = 1'b0;
    bp.redirect_pc_e = '0;
    if (bp.upd_valid_e) begin
      bp.mispredict_e  = (bp.upd_taken_e != bp.pred_taken_e) ||
                         (bp.upd_taken_e && (bp.upd_target_e != bp.pred_pc_e));
      bp.redirect_pc_e = bp.upd_taken_e ? bp.upd_target_e : bp.upd_pc_e + 32'd4;
    end
  end

  // ---- training ----
  logic [IDX_W-1:0] u_idx;
  logic             u_hit;
  bp_ctr_t          u_ctr_sat;
  logic             upd_we;
  bp_entry_t        upd_entry_d;
  bp_ctr_t          upd_ctr_d;

  assign u_idx = bp.upd_pc_e[IDX_W+1:2];
  assign u_hit = entry_q[u_idx].valid && (entry_q[u_idx].tag == tag_of(bp.upd_pc_e));

  bp_sat_ctr u_sat_ctr (
    .ctr_i (ctr_q[u_idx]),
    .inc_i (bp.upd_taken_e),
    .ctr_o (u_ctr_sat)
  );

  // next contents of the indexed entry; not-taken misses leave the table alone
  always_comb begin
    upd_we      = 1'b0;
    upd_entry_d = entry_q[u_idx];
    upd_ctr_d   = ctr_q[u_idx];
    if (bp.upd_valid_e) begin
      if (bp.upd_taken_e) begin
        upd_we              = 1'b1;
        upd_entry_d.valid   = 1'b1;
        upd_entry_d.is_jump = bp.upd_is_jump_e;
        upd_entry_d.tag     = tag_of(bp.upd_pc_e);
        upd_entry_d.target  = bp.upd_target_e;
        upd_ctr_d           = u_hit ? u_ctr_sat : BP_CTR_ALLOC;
      end else if (u_hit) begin
        upd_we    = 1'b1;
        upd_ctr_d = u_ctr_sat;
      end
    end
  end

  // table write; reset wins over any update presented on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '{default: '0};
      ctr_q   <= '{default: BP_CTR_RESET};
    end else if (upd_we) begin
      entry_q[u_idx] <= upd_entry_d;
      ctr_q[u_idx]   <= upd_ctr_d;
    end
  end

  // resolution statistics, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (bp.upd_valid_e) begin
      branch_cnt_q  <= branch_cnt_q + 32'd1;
      if (bp.mispredict_e) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign bp.branch_cnt  = branch_cnt_q;
  assign bp.mispred_cnt = mispred_cnt_q;

endmodule
